vrf_elem_sequencer: RTL

- Element-serial controller for the vector register file (VRF).
- Accepts one vector command (vs1, vs2, vd, vl) at a time.
- Walks element indices 0..vl-1 on both VRF read ports and streams operand pairs to the execution lane over a valid/ready interface.
- Collects in-order results from the lane and writes them back to vd through the VRF write port. It is the sole master of the VRF read and write ports.

---
 rtl/vrf_seq_pkg.sv | 14 +
 rtl/vrf_seq_opslot.sv | 52 +++++
 rtl/vrf_elem_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/vrf_seq_pkg.sv
// vrf_seq_pkg: shared types and default geometry for the VRF element sequencer.
package vrf_seq_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NE = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [AW-1:0] vs1;
    logic [AW-1:0] vs2;
    logic [AW-1:0] vd;
    logic [AW:0]   vl;
    logic          wb;
  } cmd_t;
endpackage

// File: rtl/vrf_seq_opslot.sv
// vrf_seq_opslot: single-entry operand register; contents hold until op_ready.
module vrf_seq_opslot #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          op_ready,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic [AW-1:0] idx_in,
  input  logic          last_in,
  output logic          free,
  output logic          op_valid,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [AW-1:0] op_idx,
  output logic          op_last
);
  logic          valid_q, valid_d, last_q, last_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0] idx_q, idx_d;
  always_comb begin
    valid_d = load ? 1'b1 : (op_ready ? 1'b0 : valid_q);
    a_d     = load ? a_in : a_q;
    b_d     = load ? b_in : b_q;
    idx_d   = load ? idx_in : idx_q;
    last_d  = load ? last_in : last_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end
  assign free     = !valid_q || op_ready;
  assign op_valid = valid_q;
  assign op_a     = a_q;
  assign op_b     = b_q;
  assign op_idx   = idx_q;
  assign op_last  = last_q;
endmodule

// File: rtl/vrf_elem_sequencer.sv
// vrf_elem_sequencer: walks a vector command element by element, streams operands
// to the lane and writes in-order results back to the destination register.
module vrf_elem_sequencer
  import vrf_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = AW,
  parameter int DATA_WIDTH = DW,
  parameter int NUM_ELE    = NE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_vs1,
  input  logic [ADDR_WIDTH-1:0] cmd_vs2,
  input  logic [ADDR_WIDTH-1:0] cmd_vd,
  input  logic [ADDR_WIDTH:0]   cmd_vl,
  input  logic                  cmd_wb,
  output logic [ADDR_WIDTH-1:0] rAddr1_1,
  output logic [ADDR_WIDTH-1:0] rAddr2_1,
  input  logic [DATA_WIDTH-1:0] rData1,
  output logic [ADDR_WIDTH-1:0] rAddr1_2,
  output logic [ADDR_WIDTH-1:0] rAddr2_2,
  input  logic [DATA_WIDTH-1:0] rData2,
  output logic [ADDR_WIDTH-1:0] wAddr1,
  output logic [ADDR_WIDTH-1:0] wAddr2,
  output logic [DATA_WIDTH-1:0] wData,
  output logic                  wEnable,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [ADDR_WIDTH-1:0] op_idx,
  output logic                  op_last,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy,
  output logic                  done
);
  localparam logic [ADDR_WIDTH:0] VL_MAX = (ADDR_WIDTH + 1)'(NUM_ELE);
  state_t                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] iss_q, iss_d, wbi_q, wbi_d;
  logic [ADDR_WIDTH:0]   vl_in, vl_m1;
  logic                  free, capture, last_iss, last_wb, op_clear;
  assign vl_in     = cmd_vl > VL_MAX ? VL_MAX : cmd_vl;
  assign vl_m1     = cmd_q.vl - 1'b1;
  assign last_iss  = {1'b0, iss_q} == vl_m1;
  assign last_wb   = {1'b0, wbi_q} == vl_m1;
  assign capture   = state_q == ISSUE && free;
  assign op_clear  = !op_valid || op_ready;
  assign res_ready = (state_q == ISSUE || state_q == DRAIN) && cmd_q.wb;
  assign wEnable   = res_valid && res_ready;
  assign wAddr1    = cmd_q.vd;
  assign wAddr2    = wbi_q;
  assign wData     = res_data;
  assign rAddr1_1  = cmd_q.vs1;
  assign rAddr1_2  = cmd_q.vs2;
  assign rAddr2_1  = iss_q;
  assign rAddr2_2  = iss_q;
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  // Indices saturate at vl_eff-1 so addresses never wrap past the last element.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    iss_d   = iss_q;
    wbi_d   = (wEnable && !last_wb) ? wbi_q + 1'b1 : wbi_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        cmd_d   = '{vs1: cmd_vs1, vs2: cmd_vs2, vd: cmd_vd, vl: vl_in, wb: cmd_wb};
        iss_d   = '0;
        wbi_d   = '0;
        state_d = vl_in != '0 ? ISSUE : DONE;
      end
      ISSUE: if (capture) begin
        iss_d   = last_iss ? iss_q : iss_q + 1'b1;
        state_d = last_iss ? DRAIN : ISSUE;
      end
      DRAIN: state_d = (op_clear && (!cmd_q.wb || (wEnable && last_wb))) ? DONE : DRAIN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      iss_q   <= '0;
      wbi_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      iss_q   <= iss_d;
      wbi_q   <= wbi_d;
    end
  end
  vrf_seq_opslot #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_slot (
    .clk     (clk),
    .reset   (reset),
    .load    (capture),
    .op_ready(op_ready),
    .a_in    (rData1),
    .b_in    (rData2),
    .idx_in  (iss_q),
    .last_in (last_iss),
    .free    (free),
    .op_valid(op_valid),
    .op_a    (op_a),
    .op_b    (op_b),
    .op_idx  (op_idx),
    .op_last (op_last)
  );
endmodule
